// File: rtl/vrb_pkg.sv
// -----------------------------------------------------------------------------
// vrb_pkg
// Shared definitions for the VRB fabric: master ids and the command and
// response bundles. Other arbiters and slaves can import these definitions.
// No ports (package).
// -----------------------------------------------------------------------------
package vrb_pkg;

   // Default fabric widths used by the bundle structs below.
   localparam int unsigned VRB_AW = 32;
   localparam int unsigned VRB_DW = 32;
   localparam int unsigned VRB_MW = VRB_DW / 8;

   // Master ids stored in the response-routing FIFO.
   localparam logic MID_IFU = 1'b0;
   localparam logic MID_LSU = 1'b1;

   typedef struct packed {
      logic              valid;
      logic [VRB_AW-1:0] addr;
      logic              read;
      logic [VRB_DW-1:0] wdata;
      logic [VRB_MW-1:0] wmask;
   } vrb_cmd_t;

   typedef struct packed {
      logic              valid;
      logic              err;
      logic [VRB_DW-1:0] rdata;
   } vrb_rsp_t;

   // Maps the "LSU granted" decision onto the id that is pushed.
   function automatic logic mid_of_gnt(input logic gnt_lsu);
      logic mid;
      if (gnt_lsu) begin
         mid = MID_LSU;
      end else begin
         mid = MID_IFU;
      end
      return mid;
   endfunction

endpackage

// File: rtl/vrb_id_fifo.sv
// -----------------------------------------------------------------------------
// vrb_id_fifo
// 1-bit wide, DEPTH-deep synchronous FIFO that records which master owns
// each accepted command, so in-order responses can be routed back.
// Pointers carry one extra wrap bit: full when the wrap bits differ and the
// index bits are equal, empty when the pointers are identical.
// A push and a pop may happen in the same cycle (also when full: the pop
// frees the head while the push is refused by the full check; the caller
// never pushes while full).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset (flushes the FIFO)
//   i_push     in   write i_push_id at the tail
//   i_push_id  in   id to store
//   i_pop      in   drop the head entry
//   o_pop_id   out  head entry (valid when o_empty is 0)
//   o_full     out  DEPTH entries stored
//   o_empty    out  no entries stored
// -----------------------------------------------------------------------------
module vrb_id_fifo #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_push,
   input  logic i_push_id,
   input  logic i_pop,
   output logic o_pop_id,
   output logic o_full,
   output logic o_empty
);

   localparam int unsigned PW = $clog2(DEPTH) + 1;
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // XOR pattern of the two pointers when exactly DEPTH entries are stored.
   localparam logic [PW-1:0] FULL_XOR = PW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    rd_ptr_d;
   logic [DEPTH-1:0] mem_q;
   logic [DEPTH-1:0] mem_d;
   logic [IW-1:0]    wr_idx_s;
   logic [IW-1:0]    rd_idx_s;
   logic             full_s;
   logic             empty_s;
   logic             do_push_s;
   logic             do_pop_s;

   // A single-entry FIFO has no index bits; its only slot is entry 0.
   generate
      if (DEPTH > 1) begin : g_idx
         assign wr_idx_s = wr_ptr_q[IW-1:0];
         assign rd_idx_s = rd_ptr_q[IW-1:0];
      end else begin : g_idx_one
         assign wr_idx_s = 1'b0;
         assign rd_idx_s = 1'b0;
      end
   endgenerate

   assign full_s    = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
   assign empty_s   = (wr_ptr_q == rd_ptr_q);
   assign do_push_s = i_push & ~full_s;
   assign do_pop_s  = i_pop & ~empty_s;

   assign o_full   = full_s;
   assign o_empty  = empty_s;
   assign o_pop_id = mem_q[rd_idx_s];

   // Next-state for storage and pointers.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push_s) begin
         mem_d[wr_idx_s] = i_push_id;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // State registers with synchronous flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/vrb_arb2.sv
// -----------------------------------------------------------------------------
// vrb_arb2
// Two-master to one-slave VRB arbiter sitting right after the cpu core.
// m1 (LSU) has fixed priority over m0 (IFU). Commands pass through with zero
// added latency, responses are routed back with zero added latency using an
// in-order id FIFO. o_holding stalls the cpu while any requesting master has
// not been accepted this cycle.
//
// While the cpu is frozen its command outputs stay asserted, so a master that
// was already accepted during the freeze is marked "served" and ignored until
// the freeze ends; this prevents issuing the same command twice.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   i_m0_cmd_*  / o_m0_rsp_*   IFU command in, response out
//   i_m1_cmd_*  / o_m1_rsp_*   LSU command in, response out
//   o_s_cmd_*, i_s_cmd_ready   slave command out with ready handshake
//   i_s_rsp_*                  slave response in (one per accepted command)
//   o_holding                  stall request to the cpu (combinational)
//   o_orphan                   registered pulse: response with nothing
//                              outstanding
// -----------------------------------------------------------------------------
module vrb_arb2
   import vrb_pkg::*;
#(
   parameter int unsigned AW   = 32,
   parameter int unsigned DW   = 32,
   parameter int unsigned OSTD = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_m0_cmd_valid,
   input  logic [AW-1:0]   i_m0_cmd_addr,
   input  logic            i_m0_cmd_read,
   input  logic [DW-1:0]   i_m0_cmd_wdata,
   input  logic [DW/8-1:0] i_m0_cmd_wmask,
   output logic            o_m0_rsp_valid,
   output logic            o_m0_rsp_err,
   output logic [DW-1:0]   o_m0_rsp_rdata,
   input  logic            i_m1_cmd_valid,
   input  logic [AW-1:0]   i_m1_cmd_addr,
   input  logic            i_m1_cmd_read,
   input  logic [DW-1:0]   i_m1_cmd_wdata,
   input  logic [DW/8-1:0] i_m1_cmd_wmask,
   output logic            o_m1_rsp_valid,
   output logic            o_m1_rsp_err,
   output logic [DW-1:0]   o_m1_rsp_rdata,
   output logic            o_s_cmd_valid,
   input  logic            i_s_cmd_ready,
   output logic [AW-1:0]   o_s_cmd_addr,
   output logic            o_s_cmd_read,
   output logic [DW-1:0]   o_s_cmd_wdata,
   output logic [DW/8-1:0] o_s_cmd_wmask,
   input  logic            i_s_rsp_valid,
   input  logic            i_s_rsp_err,
   input  logic [DW-1:0]   i_s_rsp_rdata,
   output logic            o_holding,
   output logic            o_orphan
);

   logic served_m0_q;
   logic served_m0_d;
   logic served_m1_q;
   logic served_m1_d;
   logic orphan_q;
   logic orphan_d;

   logic req_m0_s;
   logic req_m1_s;
   logic gnt_m0_s;
   logic gnt_m1_s;
   logic cmd_valid_s;
   logic acc_s;
   logic holding_s;
   logic fifo_full_s;
   logic fifo_empty_s;
   logic head_id_s;
   logic pop_s;

   // ---------------------------------------------------------------------
   // Request qualification and fixed-priority grant
   // ---------------------------------------------------------------------
   assign req_m0_s = i_m0_cmd_valid & ~served_m0_q;
   assign req_m1_s = i_m1_cmd_valid & ~served_m1_q;
   assign gnt_m1_s = req_m1_s;
   assign gnt_m0_s = req_m0_s & ~req_m1_s;

   // Full is taken before any same-cycle pop so that the slave never sees a
   // command that depends on a response arriving in the same cycle.
   assign cmd_valid_s = (req_m0_s | req_m1_s) & ~fifo_full_s;
   assign acc_s       = cmd_valid_s & i_s_cmd_ready;

   assign holding_s = (req_m0_s & ~(acc_s & gnt_m0_s))
                    | (req_m1_s & ~(acc_s & gnt_m1_s));

   assign o_s_cmd_valid = cmd_valid_s;
   assign o_holding     = holding_s;
   assign o_orphan      = orphan_q;

   // Command payload mux toward the slave; zero when nobody is granted.
   always_comb begin
      o_s_cmd_addr  = '0;
      o_s_cmd_read  = 1'b0;
      o_s_cmd_wdata = '0;
      o_s_cmd_wmask = '0;
      if (gnt_m1_s) begin
         o_s_cmd_addr  = i_m1_cmd_addr;
         o_s_cmd_read  = i_m1_cmd_read;
         o_s_cmd_wdata = i_m1_cmd_wdata;
         o_s_cmd_wmask = i_m1_cmd_wmask;
      end else if (gnt_m0_s) begin
         o_s_cmd_addr  = i_m0_cmd_addr;
         o_s_cmd_read  = i_m0_cmd_read;
         o_s_cmd_wdata = i_m0_cmd_wdata;
         o_s_cmd_wmask = i_m0_cmd_wmask;
      end else begin
         o_s_cmd_addr  = '0;
         o_s_cmd_read  = 1'b0;
         o_s_cmd_wdata = '0;
         o_s_cmd_wmask = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Outstanding-command id FIFO
   // ---------------------------------------------------------------------
   assign pop_s = i_s_rsp_valid & ~fifo_empty_s;

   vrb_id_fifo #(
      .DEPTH (OSTD)
   ) u_id_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (acc_s),
      .i_push_id (mid_of_gnt(gnt_m1_s)),
      .i_pop     (pop_s),
      .o_pop_id  (head_id_s),
      .o_full    (fifo_full_s),
      .o_empty   (fifo_empty_s)
   );

   // Response demux: only the owner of the head entry sees the response.
   always_comb begin
      o_m0_rsp_valid = 1'b0;
      o_m0_rsp_err   = 1'b0;
      o_m0_rsp_rdata = '0;
      o_m1_rsp_valid = 1'b0;
      o_m1_rsp_err   = 1'b0;
      o_m1_rsp_rdata = '0;
      if (pop_s) begin
         if (head_id_s == MID_LSU) begin
            o_m1_rsp_valid = 1'b1;
            o_m1_rsp_err   = i_s_rsp_err;
            o_m1_rsp_rdata = i_s_rsp_rdata;
         end else begin
            o_m0_rsp_valid = 1'b1;
            o_m0_rsp_err   = i_s_rsp_err;
            o_m0_rsp_rdata = i_s_rsp_rdata;
         end
      end else begin
         o_m0_rsp_valid = 1'b0;
         o_m1_rsp_valid = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Served flags and orphan pulse
   // ---------------------------------------------------------------------
   // Served flags only accumulate during a freeze; the first unfrozen cycle
   // clears them because the cpu then moves on to new commands.
   always_comb begin
      served_m0_d = served_m0_q;
      served_m1_d = served_m1_q;
      if (holding_s) begin
         served_m0_d = served_m0_q | (acc_s & gnt_m0_s);
         served_m1_d = served_m1_q | (acc_s & gnt_m1_s);
      end else begin
         served_m0_d = 1'b0;
         served_m1_d = 1'b0;
      end
   end

   assign orphan_d = i_s_rsp_valid & fifo_empty_s;

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         served_m0_q <= 1'b0;
         served_m1_q <= 1'b0;
         orphan_q    <= 1'b0;
      end else begin
         served_m0_q <= served_m0_d;
         served_m1_q <= served_m1_d;
         orphan_q    <= orphan_d;
      end
   end

endmodule

// File: tb/tb_vrb_arb2.sv
// -----------------------------------------------------------------------------
// tb_vrb_arb2
// Directed bench for vrb_arb2 with hand-computed expected values.
// Inputs change 1 ns after the rising edge; outputs are checked 3 ns after
// the rising edge, well before the next one.
// -----------------------------------------------------------------------------
module tb_vrb_arb2;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            m0_valid;
   logic [AW-1:0]   m0_addr;
   logic            m0_read;
   logic [DW-1:0]   m0_wdata;
   logic [DW/8-1:0] m0_wmask;
   logic            m0_rsp_valid;
   logic            m0_rsp_err;
   logic [DW-1:0]   m0_rsp_rdata;
   logic            m1_valid;
   logic [AW-1:0]   m1_addr;
   logic            m1_read;
   logic [DW-1:0]   m1_wdata;
   logic [DW/8-1:0] m1_wmask;
   logic            m1_rsp_valid;
   logic            m1_rsp_err;
   logic [DW-1:0]   m1_rsp_rdata;
   logic            s_cmd_valid;
   logic            s_cmd_ready;
   logic [AW-1:0]   s_cmd_addr;
   logic            s_cmd_read;
   logic [DW-1:0]   s_cmd_wdata;
   logic [DW/8-1:0] s_cmd_wmask;
   logic            s_rsp_valid;
   logic            s_rsp_err;
   logic [DW-1:0]   s_rsp_rdata;
   logic            holding;
   logic            orphan;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   vrb_arb2 #(.AW(AW), .DW(DW), .OSTD(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_m0_cmd_valid (m0_valid),
      .i_m0_cmd_addr  (m0_addr),
      .i_m0_cmd_read  (m0_read),
      .i_m0_cmd_wdata (m0_wdata),
      .i_m0_cmd_wmask (m0_wmask),
      .o_m0_rsp_valid (m0_rsp_valid),
      .o_m0_rsp_err   (m0_rsp_err),
      .o_m0_rsp_rdata (m0_rsp_rdata),
      .i_m1_cmd_valid (m1_valid),
      .i_m1_cmd_addr  (m1_addr),
      .i_m1_cmd_read  (m1_read),
      .i_m1_cmd_wdata (m1_wdata),
      .i_m1_cmd_wmask (m1_wmask),
      .o_m1_rsp_valid (m1_rsp_valid),
      .o_m1_rsp_err   (m1_rsp_err),
      .o_m1_rsp_rdata (m1_rsp_rdata),
      .o_s_cmd_valid  (s_cmd_valid),
      .i_s_cmd_ready  (s_cmd_ready),
      .o_s_cmd_addr   (s_cmd_addr),
      .o_s_cmd_read   (s_cmd_read),
      .o_s_cmd_wdata  (s_cmd_wdata),
      .o_s_cmd_wmask  (s_cmd_wmask),
      .i_s_rsp_valid  (s_rsp_valid),
      .i_s_rsp_err    (s_rsp_err),
      .i_s_rsp_rdata  (s_rsp_rdata),
      .o_holding      (holding),
      .o_orphan       (orphan)
   );

   // Single comparison point: counts every check, reports each mismatch.
   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      m0_valid    = 1'b0;
      m0_addr     = '0;
      m0_read     = 1'b0;
      m0_wdata    = '0;
      m0_wmask    = '0;
      m1_valid    = 1'b0;
      m1_addr     = '0;
      m1_read     = 1'b0;
      m1_wdata    = '0;
      m1_wmask    = '0;
      s_cmd_ready = 1'b0;
      s_rsp_valid = 1'b0;
      s_rsp_err   = 1'b0;
      s_rsp_rdata = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic m0_req(input logic [AW-1:0] addr);
      m0_valid = 1'b1;
      m0_addr  = addr;
      m0_read  = 1'b1;
   endtask

   task automatic slave_rsp(input logic err, input logic [DW-1:0] rdata);
      s_rsp_valid = 1'b1;
      s_rsp_err   = err;
      s_rsp_rdata = rdata;
   endtask

   initial begin
      // ---------------- reset state ----------------
      rst_n = 1'b0;
      idle_inputs();
      step();
      step();
      settle();
      check_val("rst_cmd_valid", 64'(s_cmd_valid), 64'd0);
      check_val("rst_holding", 64'(holding), 64'd0);
      check_val("rst_orphan", 64'(orphan), 64'd0);
      check_val("rst_m0_rsp_valid", 64'(m0_rsp_valid), 64'd0);
      check_val("rst_m1_rsp_valid", 64'(m1_rsp_valid), 64'd0);
      check_val("rst_cmd_addr", 64'(s_cmd_addr), 64'd0);
      rst_n = 1'b1;
      step();

      // ---------------- IFU-only read ----------------
      m0_req(32'h0000_0100);
      s_cmd_ready = 1'b1;
      settle();
      check_val("ifu_cmd_valid", 64'(s_cmd_valid), 64'd1);
      check_val("ifu_cmd_addr", 64'(s_cmd_addr), 64'h100);
      check_val("ifu_cmd_read", 64'(s_cmd_read), 64'd1);
      check_val("ifu_holding", 64'(holding), 64'd0);
      step();
      idle_inputs();
      slave_rsp(1'b0, 32'h0000_0013);
      settle();
      check_val("ifu_rsp_valid", 64'(m0_rsp_valid), 64'd1);
      check_val("ifu_rsp_rdata", 64'(m0_rsp_rdata), 64'h13);
      check_val("ifu_m1_rsp_valid", 64'(m1_rsp_valid), 64'd0);
      check_val("ifu_m1_rsp_rdata", 64'(m1_rsp_rdata), 64'd0);
      step();
      idle_inputs();

      // ---------------- contention ----------------
      m0_req(32'h0000_0200);
      m1_valid    = 1'b1;
      m1_addr     = 32'h8000_0000;
      m1_read     = 1'b0;
      m1_wdata    = 32'hDEAD_BEEF;
      m1_wmask    = 4'hF;
      s_cmd_ready = 1'b1;
      settle();
      check_val("cont0_cmd_addr", 64'(s_cmd_addr), 64'h8000_0000);
      check_val("cont0_cmd_read", 64'(s_cmd_read), 64'd0);
      check_val("cont0_cmd_wdata", 64'(s_cmd_wdata), 64'hDEAD_BEEF);
      check_val("cont0_cmd_wmask", 64'(s_cmd_wmask), 64'hF);
      check_val("cont0_holding", 64'(holding), 64'd1);
      step();
      settle();
      check_val("cont1_cmd_valid", 64'(s_cmd_valid), 64'd1);
      check_val("cont1_cmd_addr", 64'(s_cmd_addr), 64'h200);
      check_val("cont1_cmd_read", 64'(s_cmd_read), 64'd1);
      check_val("cont1_holding", 64'(holding), 64'd0);
      step();
      idle_inputs();
      slave_rsp(1'b0, 32'h1111_1111);
      settle();
      check_val("cont_rsp1_m1_valid", 64'(m1_rsp_valid), 64'd1);
      check_val("cont_rsp1_m1_rdata", 64'(m1_rsp_rdata), 64'h1111_1111);
      check_val("cont_rsp1_m0_valid", 64'(m0_rsp_valid), 64'd0);
      step();
      slave_rsp(1'b0, 32'h2222_2222);
      settle();
      check_val("cont_rsp2_m0_valid", 64'(m0_rsp_valid), 64'd1);
      check_val("cont_rsp2_m0_rdata", 64'(m0_rsp_rdata), 64'h2222_2222);
      check_val("cont_rsp2_m1_valid", 64'(m1_rsp_valid), 64'd0);
      step();
      idle_inputs();

      // ---------------- slave backpressure ----------------
      m1_valid = 1'b1;
      m1_addr  = 32'h0000_0300;
      m1_read  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check_val("bp_wait_holding", 64'(holding), 64'd1);
         check_val("bp_wait_cmd_valid", 64'(s_cmd_valid), 64'd1);
         step();
      end
      s_cmd_ready = 1'b1;
      settle();
      check_val("bp_acc_holding", 64'(holding), 64'd0);
      check_val("bp_acc_cmd_addr", 64'(s_cmd_addr), 64'h300);
      step();
      idle_inputs();
      slave_rsp(1'b0, 32'h0000_0333);
      settle();
      check_val("bp_rsp_m1_valid", 64'(m1_rsp_valid), 64'd1);
      step();
      idle_inputs();

      // ---------------- orphan with error (FIFO should be empty) ----------------
      slave_rsp(1'b1, 32'h0000_0BAD);
      settle();
      check_val("orph_m0_rsp_valid", 64'(m0_rsp_valid), 64'd0);
      check_val("orph_m1_rsp_valid", 64'(m1_rsp_valid), 64'd0);
      check_val("orph_same_cycle", 64'(orphan), 64'd0);
      step();
      idle_inputs();
      settle();
      check_val("orph_pulse", 64'(orphan), 64'd1);
      step();
      settle();
      check_val("orph_pulse_end", 64'(orphan), 64'd0);

      // ---------------- LSU read with error response ----------------
      m1_valid    = 1'b1;
      m1_addr     = 32'h0000_0500;
      m1_read     = 1'b1;
      s_cmd_ready = 1'b1;
      step();
      idle_inputs();
      slave_rsp(1'b1, 32'h0000_0000);
      settle();
      check_val("err_m1_rsp_valid", 64'(m1_rsp_valid), 64'd1);
      check_val("err_m1_rsp_err", 64'(m1_rsp_err), 64'd1);
      check_val("err_m0_rsp_err", 64'(m0_rsp_err), 64'd0);
      step();
      idle_inputs();

      // ---------------- FIFO full ----------------
      m0_req(32'h0000_0400);
      s_cmd_ready = 1'b1;
      step();
      m0_req(32'h0000_0404);
      settle();
      check_val("full_2nd_holding", 64'(holding), 64'd0);
      step();
      m0_req(32'h0000_0408);
      settle();
      check_val("full_cmd_valid", 64'(s_cmd_valid), 64'd0);
      check_val("full_holding", 64'(holding), 64'd1);
      step();
      slave_rsp(1'b0, 32'h0000_00A0);
      settle();
      check_val("full_pop_m0_valid", 64'(m0_rsp_valid), 64'd1);
      check_val("full_pop_m0_rdata", 64'(m0_rsp_rdata), 64'hA0);
      check_val("full_pop_cmd_valid", 64'(s_cmd_valid), 64'd0);
      step();
      s_rsp_valid = 1'b0;
      settle();
      check_val("full_after_cmd_valid", 64'(s_cmd_valid), 64'd1);
      check_val("full_after_cmd_addr", 64'(s_cmd_addr), 64'h408);
      check_val("full_after_holding", 64'(holding), 64'd0);
      step();
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         slave_rsp(1'b0, 32'h0000_00B0);
         settle();
         check_val("full_drain_m0_valid", 64'(m0_rsp_valid), 64'd1);
         step();
      end
      idle_inputs();

      // ---------------- reset mid-flight ----------------
      m0_req(32'h0000_0600);
      s_cmd_ready = 1'b1;
      step();
      m1_valid = 1'b1;
      m1_addr  = 32'h0000_0700;
      m1_read  = 1'b1;
      settle();
      check_val("rmf_cmd_addr", 64'(s_cmd_addr), 64'h700);
      check_val("rmf_holding", 64'(holding), 64'd1);
      step();
      rst_n       = 1'b0;
      s_cmd_ready = 1'b0;
      step();
      rst_n    = 1'b1;
      m0_valid = 1'b0;
      settle();
      // LSU is eligible again and the FIFO has room.
      check_val("rmf_served_clr", 64'(s_cmd_valid), 64'd1);
      check_val("rmf_after_addr", 64'(s_cmd_addr), 64'h700);
      step();
      idle_inputs();
      slave_rsp(1'b0, 32'h0000_0777);
      settle();
      check_val("rmf_late_m0_valid", 64'(m0_rsp_valid), 64'd0);
      check_val("rmf_late_m1_valid", 64'(m1_rsp_valid), 64'd0);
      step();
      idle_inputs();
      settle();
      check_val("rmf_orphan", 64'(orphan), 64'd1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
